uart_rx: RTL
============

# uart_rx

8N1 asynchronous serial receiver, the receive-side counterpart of the existing UART transmitter, using the same baud constants (115200 baud, 20.25 MHz system clock). It synchronises the external `RX` pin, detects and verifies start bits, samples 8 data bits LSB-first at mid-bit, and checks the stop bit. It presents each good byte on a valid/ready output held until consumed, and flags framing and overrun errors. It sits between the board pin and the debug/command logic that consumes host bytes.

## Interface
- `CLK_FREQ`, 20_250_000: system clock frequency in Hz.
- `BAUD_RATE`, 115200: line rate in bits per second.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `RX`  in  1  serial line, asynchronous to `clk`, idles high.
- `data_o`  out  8  received byte; stable while `data_valid_o` is high.
- `data_valid_o`  out  1  byte available; held until accepted.
- `data_ready_i`  in  1  consumer accepts the byte when high in the same cycle as `data_valid_o`.
- `framing_err_o`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun_o`  out  1  one-cycle pulse: a good byte completed while `data_valid_o` was still high.
- `busy_o`  out  1  high whenever state is not IDLE.

## Operation
- `PULSE_WIDTH = CLK_FREQ / BAUD_RATE` uses integer division, giving 175. `HALF = PULSE_WIDTH / 2`, giving 87.
- `RX` passes through a two-flop synchroniser; the output is `rx_s`. `rx_prev` is `rx_s` delayed by one cycle. Both flops and `rx_prev` reset to 1.
- `clk_count` is wide enough for `PULSE_WIDTH-1`. `bit_count` is 3 bits. `shift_r` is 8 bits.
- IDLE
  - Stays here until a falling edge (`rx_prev==1 && rx_s==0`).
  - On the edge: go to START with `clk_count=0`.
  - A line held low (break) does not re-trigger; a new falling edge is required.
- START
  - Increments `clk_count`.
  - At `clk_count==HALF-1`: if `rx_s==0`, go to DATA with `clk_count=0` and `bit_count=0`. Otherwise it was a glitch; go to IDLE silently.
- DATA
  - At `clk_count==PULSE_WIDTH-1`: `shift_r[bit_count] <= rx_s`, `clk_count <= 0`, `bit_count` increments.
  - After the sample with `bit_count==7`, go to STOP.
- STOP
  - At `clk_count==PULSE_WIDTH-1`, sample `rx_s` and go to IDLE.
  - Sample 1 and `data_valid_o==0`: load `data_o <= shift_r` and set `data_valid_o`.
  - Sample 1 and `data_valid_o==1`:
    - If `data_ready_i` is also high that cycle, the old byte is accepted and the new byte loads; no overrun.
    - Otherwise the new byte is dropped, `data_o` is unchanged, and `overrun_o` pulses.
  - Sample 0: pulse `framing_err_o`; the byte is discarded and `data_valid_o` is unaffected.
- `data_valid_o` clears on the cycle after `data_valid_o && data_ready_i`, unless a new byte loads in that same cycle.
- `data_o` holds its last value after it is accepted.

## Timing
- Reset values:
  - `data_o=0`, `data_valid_o=0`, `framing_err_o=0`, `overrun_o=0`, `busy_o=0`.
  - State IDLE; all counters 0; `shift_r=0`.
- Reset asserted mid-frame aborts immediately. No partial byte or error pulse is produced, and the receiver needs a fresh falling edge afterwards.
- Let t0 be the cycle in which IDLE sees the falling edge on `rx_s`. Then:
  - START is entered at t0+1.
  - DATA is entered at t0+HALF+1.
  - Data bit k is sampled at t0+HALF+(k+1)·PULSE_WIDTH.
  - The stop bit is sampled at t0+HALF+9·PULSE_WIDTH.
  - `data_valid_o` or `framing_err_o` is visible at t0+HALF+9·PULSE_WIDTH+1, which is t0+1663.
- The pin-to-`rx_s` delay is 2 cycles.
- The receiver re-arms mid-stop-bit. A back-to-back frame whose start edge arrives right at the end of the stop bit is received.
- Error pulses last exactly one cycle.

## Structure
- Shared package `uart_pkg`, used by both transmitter and receiver, contains:
  - `CLK_FREQ`, `BAUD_RATE`, `PULSE_WIDTH` and `HALF` constants;
  - `state_t` enum {IDLE, START, DATA, STOP}.
- One sub-module, `sync_2ff` (parameterised reset value, default 1), handles the `RX` synchroniser.
- The rest is a single module: a next-state `always_comb` plus sequential blocks with the async active-low reset.

## Test plan
- Byte 0xA5 at 115200 baud with `data_ready_i=1` → `data_o=0xA5`, `data_valid_o` high for 1 cycle, 1663 cycles after the detected edge; no error pulses.
- `RX` low for 40 cycles, then high → returns to IDLE from START; no valid, no error, `busy_o` drops after HALF cycles.
- Byte 0x3C with stop bit driven low → `framing_err_o` pulses once, `data_valid_o` stays 0; a following good frame 0x3D is received as 0x3D.
- Bytes 0x11 then 0x22 back-to-back with `data_ready_i=0` → `data_o` stays 0x11 and `overrun_o` pulses once at the second stop sample; asserting ready then clears valid.
- `rst` asserted at bit 4 of 0xFF, released, then 0x5A sent → no output from the aborted frame; 0x5A received correctly.
- Bytes 0x00 and 0xFF, plus `RX` held low for 3 frame times (break) → 0x00 and 0xFF received correctly; the break gives one framing error and no re-trigger until `RX` returns high.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding, used by both the
// transmitter and the receiver.
package uart_pkg;

  localparam int CLK_FREQ    = 32'd20_250_000;
  localparam int BAUD_RATE   = 32'd115_200;
  localparam int PULSE_WIDTH = CLK_FREQ / BAUD_RATE;
  localparam int HALF        = PULSE_WIDTH / 32'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit, with a
// configurable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic q_r;

  // Metastability filter: two back-to-back flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_r <= RST_VAL;
      q_r    <= RST_VAL;
    end else begin
      meta_r <= d;
      q_r    <= meta_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, stop-bit check, valid/ready byte
// output with framing and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = uart_pkg::CLK_FREQ,
  parameter int BAUD_RATE = uart_pkg::BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  output logic [7:0] data_o,
  output logic       data_valid_o,
  input  logic       data_ready_i,
  output logic       framing_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int BIT_CYCLES  = CLK_FREQ / BAUD_RATE;
  localparam int HALF_CYCLES = BIT_CYCLES / 32'd2;
  localparam int CNT_W       = $clog2(BIT_CYCLES);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);

  state_t           state_r, state_s;
  logic [CNT_W-1:0] clk_count_r, clk_count_s;
  logic [2:0]       bit_count_r, bit_count_s;
  logic [7:0]       shift_r, shift_s;
  logic             rx_s;
  logic             rx_prev_r;
  logic             stop_hit_s;
  logic             load_s, overrun_s, framing_s, accept_s;
  logic [7:0]       data_r;
  logic             valid_r, ferr_r, ovr_r, busy_r;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (RX),
    .q   (rx_s)
  );

  // Next-state, bit timing and shift-register update.
  always_comb begin
    state_s     = state_r;
    clk_count_s = clk_count_r;
    bit_count_s = bit_count_r;
    shift_s     = shift_r;
    stop_hit_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (rx_prev_r && !rx_s) begin
          state_s     = START;
          clk_count_s = '0;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (clk_count_r == HALF_LAST) begin
          clk_count_s = '0;
          if (!rx_s) begin
            state_s     = DATA;
            bit_count_s = 3'd0;
          end else begin
            state_s = IDLE;
          end
        end else begin
          clk_count_s = clk_count_r + CNT_ONE;
        end
      end
      DATA: begin
        if (clk_count_r == BIT_LAST) begin
          clk_count_s          = '0;
          shift_s[bit_count_r] = rx_s;
          bit_count_s          = bit_count_r + 3'd1;
          if (bit_count_r == 3'd7) begin
            state_s = STOP;
          end else begin
            state_s = DATA;
          end
        end else begin
          clk_count_s = clk_count_r + CNT_ONE;
        end
      end
      STOP: begin
        if (clk_count_r == BIT_LAST) begin
          clk_count_s = '0;
          stop_hit_s  = 1'b1;
          state_s     = IDLE;
        end else begin
          clk_count_s = clk_count_r + CNT_ONE;
        end
      end
      default: begin
        state_s     = IDLE;
        clk_count_s = '0;
      end
    endcase
  end

  // A byte may load when the output slot is empty or being drained this cycle.
  assign accept_s  = valid_r & data_ready_i;
  assign load_s    = stop_hit_s & rx_s & (~valid_r | data_ready_i);
  assign overrun_s = stop_hit_s & rx_s & valid_r & ~data_ready_i;
  assign framing_s = stop_hit_s & ~rx_s;

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      clk_count_r <= '0;
      bit_count_r <= 3'd0;
      shift_r     <= 8'h00;
      rx_prev_r   <= 1'b1;
      data_r      <= 8'h00;
      valid_r     <= 1'b0;
      ferr_r      <= 1'b0;
      ovr_r       <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      clk_count_r <= clk_count_s;
      bit_count_r <= bit_count_s;
      shift_r     <= shift_s;
      rx_prev_r   <= rx_s;
      ferr_r      <= framing_s;
      ovr_r       <= overrun_s;
      busy_r      <= (state_s != IDLE);
      if (load_s) begin
        data_r  <= shift_r;
        valid_r <= 1'b1;
      end else if (accept_s) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign data_o        = data_r;
  assign data_valid_o  = valid_r;
  assign framing_err_o = ferr_r;
  assign overrun_o     = ovr_r;
  assign busy_o        = busy_r;

endmodule
